// File: rtl/icache_refill_unit_pkg.sv
// Shared fetch-stage defines for the I-cache refill path: widths, beat count,
// block offset width and the refill FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package icache_refill_unit_pkg;

  // Address and block geometry of the L1 I-cache fill path
  localparam int REFILL_SIZE_PC     = 32;
  localparam int REFILL_CACHE_WIDTH = 256;
  localparam int REFILL_MEM_WIDTH   = 64;

  // Derived: beats per block, beat counter width, byte offset inside a block
  localparam int REFILL_BEATS       = REFILL_CACHE_WIDTH / REFILL_MEM_WIDTH;
  localparam int REFILL_BEAT_CNT_W  = $clog2(REFILL_BEATS);
  localparam int REFILL_BLK_OFF_W   = $clog2(REFILL_CACHE_WIDTH / 8);

  // Refill FSM encoding; IDLE must stay at zero so reset lands there
  localparam int REFILL_STATE_W = 3;

  typedef enum logic [REFILL_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEAT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_COOL  = 3'd4
  } refill_state_e;

endpackage

// File: rtl/refill_beat_buffer.sv
// Beat assembly buffer: counts return beats and drops each into its block slot.
// Latency: a beat is visible in o_block the cycle after i_wr.
// Backpressure: none; the caller only pulses i_wr for accepted beats.
module refill_beat_buffer
  import icache_refill_unit_pkg::*;
#(
  parameter int CACHE_WIDTH = REFILL_CACHE_WIDTH,
  parameter int MEM_WIDTH   = REFILL_MEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clr,
  input  logic                   i_wr,
  input  logic [MEM_WIDTH-1:0]   i_dat,
  output logic                   o_last_beat,
  output logic [CACHE_WIDTH-1:0] o_block
);

  localparam int BEATS = CACHE_WIDTH / MEM_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]       r_cnt;
  logic [CACHE_WIDTH-1:0] r_block;

  // Beat counter: cleared when the request is granted, steps on each accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_wr) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Assembly register: beat k lands in bits [k*MEM_WIDTH +: MEM_WIDTH]; reset discards partial blocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_block <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_wr && (r_cnt == CNT_W'(k))) begin
          r_block[k*MEM_WIDTH +: MEM_WIDTH] <= i_dat;
        end
      end
    end
  end

  assign o_last_beat = (r_cnt == CNT_W'(BEATS - 1));
  assign o_block     = r_block;

endmodule

// File: rtl/icache_refill_unit.sv
// L1 I-cache refill: latches a miss, issues one block read, assembles beats, fills the cache.
// Latency: min BEATS+2 cycles from miss sample to wrEnable_o; one cool-down cycle after the fill.
// Backpressure: REQ holds until memGnt_i; BEAT stretches across memValid_i gaps, no timeout.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int SIZE_PC     = REFILL_SIZE_PC,
  parameter int CACHE_WIDTH = REFILL_CACHE_WIDTH,
  parameter int MEM_WIDTH   = REFILL_MEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  output logic                   memReq_o,
  output logic [SIZE_PC-1:0]     memAddr_o,
  input  logic                   memGnt_i,
  input  logic                   memValid_i,
  input  logic [MEM_WIDTH-1:0]   memData_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o
);

  // Byte offset bits inside one cache block; these are cleared on the latched address
  localparam int OFF_W = $clog2(CACHE_WIDTH / 8);

  refill_state_e          r_state;
  refill_state_e          w_next_state;
  logic [SIZE_PC-1:0]     r_addr;
  logic                   w_miss_take;
  logic                   w_gnt_take;
  logic                   w_beat_take;
  logic                   w_last_beat;
  logic [CACHE_WIDTH-1:0] w_block;
  logic                   w_unused_off;

  // Qualified events: each input only counts in the one state that listens to it
  assign w_miss_take = (r_state == ST_IDLE) && miss_i;
  assign w_gnt_take  = (r_state == ST_REQ)  && memGnt_i;
  assign w_beat_take = (r_state == ST_BEAT) && memValid_i;

  // The in-block offset of the miss address is intentionally dropped
  assign w_unused_off = ^missAddr_i[OFF_W-1:0];

  refill_beat_buffer #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .MEM_WIDTH   (MEM_WIDTH)
  ) u_beat_buffer (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_gnt_take),
    .i_wr        (w_beat_take),
    .i_dat       (memData_i),
    .o_last_beat (w_last_beat),
    .o_block     (w_block)
  );

  // Address latch: captured once per refill in IDLE; a later miss during the refill is not latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_miss_take) begin
      r_addr <= {missAddr_i[SIZE_PC-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: miss dropping after IDLE never aborts; COOL ignores miss for one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_miss_take) w_next_state = ST_REQ;
      ST_REQ:   if (w_gnt_take)  w_next_state = ST_BEAT;
      ST_BEAT:  if (w_beat_take && w_last_beat) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = ST_COOL;
      ST_COOL:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: strobes come straight from state, data/address from registers
  always_comb begin
    memReq_o   = 1'b0;
    wrEnable_o = 1'b0;
    busy_o     = 1'b1;
    case (r_state)
      ST_IDLE:  busy_o     = 1'b0;
      ST_REQ:   memReq_o   = 1'b1;
      ST_WRITE: wrEnable_o = 1'b1;
      default:  busy_o     = 1'b1;
    endcase
  end

  assign memAddr_o   = r_addr;
  assign wrAddr_o    = r_addr;
  assign instBlock_o = w_block;

endmodule
